framing_decoding: RTL and testbench
===================================

FRAMING_DECODING -- requirements
Module: framing_decoding

Interface
REQ-001 SHALL have parameter SFD, default 16'h904E: start-of-frame delimiter matched on the serial bitstream.
REQ-002 SHALL have parameter MAX_LEN, default 11'd2047: largest accepted PHR length in octets.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16'd4096: idle-clock limit, used only under the configuration macro.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port bit_in, input, 1: received serial bit, MSB-first per octet.
REQ-007 SHALL have port bit_in_valid, input, 1: bit_in qualifier, one bit per asserted cycle.
REQ-008 SHALL have port psdu_out, output, 8: de-whitened payload octet.
REQ-009 SHALL have port psdu_out_valid, output, 1: one-cycle strobe per payload octet.
REQ-010 SHALL have port phr_len, output, 11: length field of current frame, held until next PHR completes.
REQ-011 SHALL have port frame_start, output, 1: one-cycle pulse on SFD match.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at end of PSDU.
REQ-013 SHALL have port crc_ok, output, 1: FCS result, valid with frame_done, held until next frame_start.
REQ-014 SHALL have port frame_err, output, 1: one-cycle pulse on length error or timeout abort.

Function
REQ-015 SHALL implement states IDLE, PHR and PSDU; all state changes and bit consumption occur only on cycles with bit_in_valid=1, except timeout.
REQ-016 IDLE SHALL shift bits into a 16-bit register and, when it equals SFD, pulse frame_start on the next cycle and enter PHR.
REQ-017 PHR SHALL collect 16 bits MSB-first: bits[10:0] are the length L (octets, including the 2-octet FCS) and bit 12 is DW (whitening enable); the other bits are ignored.
REQ-018 On the 16th PHR bit, SHALL load phr_len=L; if L<3 or L>MAX_LEN, SHALL pulse frame_err and enter IDLE; otherwise SHALL enter PSDU.
REQ-019 On PSDU entry, SHALL seed the PN9 register to 9'h1FF and the CRC to 16'h0000.
REQ-020 For each PSDU bit: when DW=1, the de-whitened bit SHALL equal bit_in XOR pn[0], then pn <= {pn[0]^pn[5], pn[8:1]}; when DW=0, the de-whitened bit SHALL equal bit_in.
REQ-021 SHALL feed each de-whitened bit, including FCS bits, MSB-first into CRC-16 x^16+x^12+x^5+1 (non-reflected, no final XOR).
REQ-022 For each of the first L-2 octets, SHALL drive psdu_out and psdu_out_valid=1 on the cycle after its 8th bit is accepted; FCS octets SHALL NOT appear on psdu_out.
REQ-023 On the cycle after the last PSDU bit, SHALL pulse frame_done and set crc_ok=1 if and only if the CRC register equals 16'h0000; the next state SHALL be IDLE.
REQ-024 On PSDU or PHR exit, SHALL clear the SFD shift register so the next frame requires 16 fresh bits; a bit accepted on the frame_done cycle belongs to IDLE search.
REQ-025 SHALL ignore SFD patterns that occur inside PHR or PSDU.
REQ-026 bit_in_valid gaps of any length SHALL stall all state without data loss (subject to REQ-031).
REQ-027 psdu_out and psdu_out_valid SHALL be registered; latency SHALL be exactly 1 cycle from the accepting edge of the octet's last bit.

Reset
REQ-028 On rst=1, SHALL immediately enter IDLE, including mid-frame, with psdu_out=0, psdu_out_valid=0, phr_len=0, frame_start=0, frame_done=0, crc_ok=0, frame_err=0, the shift register at 0, pn=9'h1FF and crc=0.
REQ-029 A frame interrupted by reset SHALL produce no frame_done and no frame_err.

Configuration
REQ-030 Macro FRAMING_DECODING_TIMEOUT_EN SHALL control the idle-bit watchdog.
REQ-031 With the macro defined: in PHR or PSDU, after TIMEOUT_CYC consecutive cycles with bit_in_valid=0, SHALL pulse frame_err, enter IDLE and produce no frame_done.
REQ-032 Without the macro: no counter SHALL exist and PHR/PSDU SHALL wait indefinitely.

Verification
REQ-033 Preamble 0x5555, SFD 0x904E, PHR 0x0003, PSDU 00 00 00 -> frame_start pulses once, one psdu_out=0x00, frame_done with crc_ok=1, phr_len=3.
REQ-034 Same frame with PHR 0x1003 (DW=1) and on-air first PSDU octet 0xFF -> psdu_out=0x00, with all PSDU bits whitened by the bench PN9 model; crc_ok=1.
REQ-035 Frame with 10-octet payload plus correct FCS, then the same frame with one payload bit flipped -> 10 psdu_out strobes each time; crc_ok=1 then crc_ok=0.
REQ-036 PHR length 0x0002, then 0x07FF with MAX_LEN=100 -> frame_err pulses each time, no psdu_out_valid, and the next valid frame decodes.
REQ-037 bit_in_valid deasserted for 50 cycles mid-octet, then rst asserted mid-PSDU -> output is unchanged by the gap; after reset, all outputs are 0 and no frame_done occurs; with the macro and TIMEOUT_CYC=20, the gap yields frame_err.

Source files
------------

// File: rtl/framing_decoding.sv
// Serial frame decoder: SFD hunt, PHR length/whitening decode, PN9 de-whitening and CRC-16 check.
// Define FRAMING_DECODING_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles inside PHR/PSDU.
module framing_decoding #(
    parameter logic [15:0] SFD         = 16'h904E,
    parameter logic [10:0] MAX_LEN     = 11'd2047,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_in_valid,
    output logic [7:0]  psdu_out,
    output logic        psdu_out_valid,
    output logic [10:0] phr_len,
    output logic        frame_start,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, PHR, PSDU} state_t;

    state_t      state_q, state_d;
    logic [14:0] sfd_sr_q, sfd_sr_d;       // older 15 bits; the live bit completes the 16-bit window
    logic [9:0]  len_sr_q, len_sr_d;       // only the PHR bits that can still land in L are kept
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [10:0] oct_cnt_q, oct_cnt_d;
    logic [6:0]  byte_sr_q, byte_sr_d;
    logic        dw_q, dw_d;
    logic [8:0]  pn_q, pn_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  psdu_out_q, psdu_out_d;
    logic        psdu_valid_q, psdu_valid_d;
    logic [10:0] phr_len_q, phr_len_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        frame_err_q, frame_err_d;
`ifdef FRAMING_DECODING_TIMEOUT_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;
`endif

    logic        dbit;
    logic [15:0] crc_next;
    logic [7:0]  octet;
    logic [10:0] len_word;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        sfd_sr_d      = sfd_sr_q;
        len_sr_d      = len_sr_q;
        bit_cnt_d     = bit_cnt_q;
        oct_cnt_d     = oct_cnt_q;
        byte_sr_d     = byte_sr_q;
        dw_d          = dw_q;
        pn_d          = pn_q;
        crc_d         = crc_q;
        psdu_out_d    = psdu_out_q;
        psdu_valid_d  = 1'b0;
        phr_len_d     = phr_len_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        crc_ok_d      = crc_ok_q;
        frame_err_d   = 1'b0;
        dbit          = dw_q ? (bit_in ^ pn_q[0]) : bit_in;
        crc_next      = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ dbit) ? 16'h1021 : 16'h0000);
        octet         = {byte_sr_q, dbit};
        len_word      = {len_sr_q, bit_in};
`ifdef FRAMING_DECODING_TIMEOUT_EN
        idle_cnt_d    = 16'd0;
`endif

        if (bit_in_valid) begin
            case (state_q)
                IDLE: begin
                    sfd_sr_d = {sfd_sr_q[13:0], bit_in};
                    if ({sfd_sr_q, bit_in} == SFD) begin
                        frame_start_d = 1'b1;
                        crc_ok_d      = 1'b0;
                        sfd_sr_d      = 15'd0;
                        bit_cnt_d     = 4'd0;
                        state_d       = PHR;
                    end
                end
                PHR: begin
                    len_sr_d  = {len_sr_q[8:0], bit_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd3) begin
                        dw_d = bit_in;           // PHR bit 12 arrives fourth, MSB-first
                    end
                    if (bit_cnt_q == 4'd15) begin
                        phr_len_d = len_word;
                        bit_cnt_d = 4'd0;
                        if (len_word < 11'd3 || len_word > MAX_LEN) begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            pn_d      = 9'h1FF;
                            crc_d     = 16'h0000;
                            oct_cnt_d = 11'd0;
                            state_d   = PSDU;
                        end
                    end
                end
                PSDU: begin
                    if (dw_q) begin
                        pn_d = {pn_q[0] ^ pn_q[5], pn_q[8:1]};
                    end
                    crc_d     = crc_next;
                    byte_sr_d = {byte_sr_q[5:0], dbit};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        oct_cnt_d = oct_cnt_q + 11'd1;
                        if (oct_cnt_q < phr_len_q - 11'd2) begin
                            psdu_out_d   = octet;
                            psdu_valid_d = 1'b1;
                        end
                        if (oct_cnt_q == phr_len_q - 11'd1) begin
                            frame_done_d = 1'b1;
                            crc_ok_d     = (crc_next == 16'h0000);
                            state_d      = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef FRAMING_DECODING_TIMEOUT_EN
        // Counts only stalled cycles inside a frame; any accepted bit restarts the watchdog.
        if (state_q != IDLE && !bit_in_valid) begin
            if (idle_cnt_q == TIMEOUT_CYC - 16'd1) begin
                frame_err_d = 1'b1;
                sfd_sr_d    = 15'd0;
                state_d     = IDLE;
            end else begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sfd_sr_q      <= 15'd0;
            len_sr_q      <= 10'd0;
            bit_cnt_q     <= 4'd0;
            oct_cnt_q     <= 11'd0;
            byte_sr_q     <= 7'd0;
            dw_q          <= 1'b0;
            pn_q          <= 9'h1FF;
            crc_q         <= 16'h0000;
            psdu_out_q    <= 8'd0;
            psdu_valid_q  <= 1'b0;
            phr_len_q     <= 11'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            crc_ok_q      <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef FRAMING_DECODING_TIMEOUT_EN
            idle_cnt_q    <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            sfd_sr_q      <= sfd_sr_d;
            len_sr_q      <= len_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            oct_cnt_q     <= oct_cnt_d;
            byte_sr_q     <= byte_sr_d;
            dw_q          <= dw_d;
            pn_q          <= pn_d;
            crc_q         <= crc_d;
            psdu_out_q    <= psdu_out_d;
            psdu_valid_q  <= psdu_valid_d;
            phr_len_q     <= phr_len_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            crc_ok_q      <= crc_ok_d;
            frame_err_q   <= frame_err_d;
`ifdef FRAMING_DECODING_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    assign psdu_out       = psdu_out_q;
    assign psdu_out_valid = psdu_valid_q;
    assign phr_len        = phr_len_q;
    assign frame_start    = frame_start_q;
    assign frame_done     = frame_done_q;
    assign crc_ok         = crc_ok_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_framing_decoding.sv
// Scoreboard bench for framing_decoding: payload octets are queued as they are transmitted and
// popped as psdu_out_valid strobes; frame-level pulses are counted and checked per frame.
module tb_framing_decoding;

    localparam logic [15:0] TB_SFD = 16'h904E;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_in_valid;
    logic [7:0]  psdu_out;
    logic        psdu_out_valid;
    logic [10:0] phr_len;
    logic        frame_start;
    logic        frame_done;
    logic        crc_ok;
    logic        frame_err;

    always #5 clk = ~clk;

    framing_decoding #(
        .SFD        (TB_SFD),
        .MAX_LEN    (11'd100),
        .TIMEOUT_CYC(16'd20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .bit_in_valid  (bit_in_valid),
        .psdu_out      (psdu_out),
        .psdu_out_valid(psdu_out_valid),
        .phr_len       (phr_len),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .crc_ok        (crc_ok),
        .frame_err     (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    byte unsigned exp_q[$];
    byte unsigned tx_q[$];
    int n_start = 0, n_done = 0, n_err = 0, n_psdu = 0;
    int s_start, s_done, s_err, s_psdu;

    // Output monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (psdu_out_valid) begin
                n_psdu++;
                if (exp_q.size() == 0) check("psdu_unexpected", exp_q.size(), 1);
                else check("psdu_data", {24'd0, psdu_out}, {24'd0, exp_q.pop_front()});
            end
            if (frame_start) n_start++;
            if (frame_done)  n_done++;
            if (frame_err)   n_err++;
        end
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic send_bit(input logic b);
        bit_in       = b;
        bit_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_in_valid = 1'b0;
        bit_in       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    // Sends preamble, SFD, PHR and tx_q plus its FCS. flip_bit corrupts one payload bit after the
    // FCS is computed, gap_bit inserts a 50-cycle stall before that bit, stop_bit truncates the PSDU.
    task automatic send_frame(input logic [15:0] phr, input int flip_bit, input int gap_bit,
                              input int stop_bit);
        logic [15:0] fcs;
        byte unsigned data[$];
        logic [8:0] pn;
        logic [7:0] cur;
        logic d, a;
        int nbits;
        fcs = 16'h0000;
        foreach (tx_q[k]) begin
            cur = tx_q[k];
            for (int b = 7; b >= 0; b--) fcs = crc_step(fcs, cur[b]);
        end
        data = tx_q;
        data.push_back(fcs[15:8]);
        data.push_back(fcs[7:0]);
        if (flip_bit >= 0) begin
            cur = data[flip_bit / 8];
            cur[7 - (flip_bit % 8)] = ~cur[7 - (flip_bit % 8)];
            data[flip_bit / 8] = cur;
        end
        send_word(16'h5555);
        send_word(TB_SFD);
        send_word(phr);
        pn    = 9'h1FF;
        nbits = data.size() * 8;
        for (int i = 0; i < nbits; i++) begin
            if (i == stop_bit) return;
            cur = data[i / 8];
            d   = cur[7 - (i % 8)];
            if (phr[12]) begin
                a  = d ^ pn[0];
                pn = {pn[0] ^ pn[5], pn[8:1]};
            end else begin
                a = d;
            end
            if (i == gap_bit) begin
                idle(50);
`ifdef FRAMING_DECODING_TIMEOUT_EN
                return;
`endif
            end
            if ((i % 8) == 7 && (i / 8) < tx_q.size()) exp_q.push_back(cur);
            send_bit(a);
        end
    endtask

    task automatic snap();
        s_start = n_start;
        s_done  = n_done;
        s_err   = n_err;
        s_psdu  = n_psdu;
    endtask

    task automatic frame_check(input string tag, input int e_start, input int e_done,
                               input int e_err, input int e_psdu, input int e_len,
                               input int e_crc);
        check({tag, "_start"}, n_start - s_start, e_start);
        check({tag, "_done"}, n_done - s_done, e_done);
        check({tag, "_err"}, n_err - s_err, e_err);
        check({tag, "_psdu_cnt"}, n_psdu - s_psdu, e_psdu);
        check({tag, "_phr_len"}, {21'd0, phr_len}, e_len);
        check({tag, "_pending"}, exp_q.size(), 0);
        if (e_crc >= 0) check({tag, "_crc_ok"}, {31'd0, crc_ok}, e_crc);
    endtask

    initial begin
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_in_valid = 1'b0;
        idle(3);
        check("reset_outputs",
              {8'd0, psdu_out, psdu_out_valid, phr_len, frame_start, frame_done, crc_ok, frame_err},
              32'd0);
        rst = 1'b0;
        idle(2);

        // Minimum length, no whitening.
        tx_q = '{8'h00};
        snap(); send_frame(16'h0003, -1, -1, -1); idle(4);
        frame_check("min_plain", 1, 1, 0, 1, 3, 1);

        // Whitened version of the same frame.
        snap(); send_frame(16'h1003, -1, -1, -1); idle(4);
        frame_check("min_dw", 1, 1, 0, 1, 3, 1);

        // 10-octet payload containing an embedded SFD pattern, good then corrupted.
        tx_q = '{8'h90, 8'h4E, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        snap(); send_frame(16'h000C, -1, -1, -1); idle(4);
        frame_check("ten_good", 1, 1, 0, 10, 12, 1);
        snap(); send_frame(16'h000C, 13, -1, -1); idle(4);
        frame_check("ten_flip", 1, 1, 0, 10, 12, 0);
        snap(); send_frame(16'h100C, -1, -1, -1); idle(4);
        frame_check("ten_dw", 1, 1, 0, 10, 12, 1);
        // Reserved PHR bits set, DW clear.
        snap(); send_frame(16'hE80C, -1, -1, -1); idle(4);
        frame_check("ten_rsvd", 1, 1, 0, 10, 12, 1);

        // Length errors: below minimum, above MAX_LEN, and MAX_LEN+1.
        snap(); send_frame(16'h0002, -1, -1, 0); idle(4);
        frame_check("len_short", 1, 0, 1, 0, 2, -1);
        snap(); send_frame(16'h07FF, -1, -1, 0); idle(4);
        frame_check("len_7ff", 1, 0, 1, 0, 11'h7FF, -1);
        snap(); send_frame(16'h0065, -1, -1, 0); idle(4);
        frame_check("len_101", 1, 0, 1, 0, 101, -1);

        // Exactly MAX_LEN decodes.
        tx_q.delete();
        for (int i = 0; i < 98; i++) tx_q.push_back(byte'(i * 7 + 3));
        snap(); send_frame(16'h1064, -1, -1, -1); idle(4);
        frame_check("len_max", 1, 1, 0, 98, 100, 1);

        // 50-cycle stall mid-octet.
        tx_q = '{8'hA5, 8'h3C, 8'hF0};
        snap(); send_frame(16'h1005, -1, 12, -1); idle(4);
`ifdef FRAMING_DECODING_TIMEOUT_EN
        frame_check("gap_timeout", 1, 0, 1, 1, 5, -1);
`else
        frame_check("gap_stall", 1, 1, 0, 3, 5, 1);
`endif

        // Reset mid-PSDU.
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        snap(); send_frame(16'h0008, -1, -1, 28);
        check("pre_reset_len", {21'd0, phr_len}, 8);
        rst = 1'b1;
        #2;
        check("mid_reset_outputs",
              {8'd0, psdu_out, psdu_out_valid, phr_len, frame_start, frame_done, crc_ok, frame_err},
              32'd0);
        idle(3);
        rst = 1'b0;
        idle(30);
        frame_check("after_reset", 1, 0, 0, 3, 0, 0);

        // Recovery frame.
        tx_q = '{8'hDE, 8'hAD};
        snap(); send_frame(16'h1004, -1, -1, -1); idle(4);
        frame_check("recover", 1, 1, 0, 2, 4, 1);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
